cpu_trace_buffer: RTL
=====================

# cpu_trace_buffer

Synthesizable, parametrised trace capture unit for the multicycle CPU. It samples PC, opcode, FSM state and ULA result into a circular buffer, either every cycle or only on FSM state change, and stops automatically after a programmable cycle budget or on command. After stopping, it plays entries back oldest-first through a request/valid read port, so the bench and on-chip debug no longer depend on a free-running simulation monitor.

## Interface
- DATA_W, 64, width of PC and ULA samples
- STATE_W, 5, width of CPU FSM state
- DEPTH, 16, entries in trace buffer; power of two, ≥2
- MAX_CYCLES, 30, CAPTURE cycles before auto-stop; 0 disables auto-stop
- CNT_W, $clog2(DEPTH+1), width of count output

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  pulse: clear buffer, enter CAPTURE
- stop  in  1  pulse: force STOPPED
- mode  in  1  0 = sample every cycle, 1 = sample only on estado_in change
- pc_in  in  DATA_W  CPU PC
- opcode_in  in  32  CPU instruction word
- estado_in  in  STATE_W  CPU FSM state
- ula_in  in  DATA_W  ULA result
- rd_req  in  1  pop oldest entry (honoured in STOPPED only)
- rd_valid  out  1  read data valid, single-cycle pulse
- rd_pc  out  DATA_W  popped PC
- rd_opcode  out  32  popped opcode
- rd_estado  out  STATE_W  popped state
- rd_ula  out  DATA_W  popped ULA value
- count  out  CNT_W  entries held, 0..DEPTH
- capturing  out  1  FSM in CAPTURE
- stopped  out  1  FSM in STOPPED
- overflow  out  1  sticky: at least one entry overwritten

## Operation
- FSM: IDLE → CAPTURE on start; CAPTURE → STOPPED on stop, or when cycle counter reaches MAX_CYCLES (MAX_CYCLES≠0); STOPPED → CAPTURE on start. stop in IDLE → STOPPED with empty buffer.
- start, from any state: clears wr_ptr, rd_ptr, count, cycle counter and overflow; start takes priority over stop and rd_req on the same edge.
- CAPTURE sampling: mode 0 writes every cycle; mode 1 writes when estado_in ≠ registered previous estado. The first CAPTURE cycle always writes.
- Full buffer (count = DEPTH) plus write: overwrite oldest entry, advance rd_ptr with wr_ptr, keep count = DEPTH, set overflow.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Cycle counter increments once per CAPTURE cycle and saturates at MAX_CYCLES.
- Read: in STOPPED with count>0, rd_req pops entry at rd_ptr, then rd_ptr+1 and count−1. rd_req with count = 0, or outside STOPPED, is ignored and rd_valid stays 0.
- rd_* hold the last popped value between pops.

## Timing
- Reset (async): FSM IDLE; all outputs 0; pointers, counters, overflow and prev-estado cleared. Buffer RAM is not cleared.
- Write latency: inputs sampled at edge N; count reflects the write after edge N.
- Auto-stop: the edge that brings the cycle counter to MAX_CYCLES performs the last write, and stopped=1 after that edge. Exactly MAX_CYCLES write opportunities occur per run.
- Read latency: rd_req high at edge N → rd_valid=1 and rd_* valid during cycle N+1. Back-to-back rd_req gives one entry per cycle.
- stop and an auto-stop condition on the same edge: single transition to STOPPED; that cycle's sample is still written.
- Reset mid-capture or mid-readout: immediate return to IDLE; all buffered data is discarded.

## Configuration
- TRACE_ULA_EN defined: ULA field stored per entry, rd_ula carries captured value.
- Not defined: no ULA storage, ula_in unused, rd_ula tied to 0. All other behaviour is identical.

## Test plan
- DEPTH=4, MAX_CYCLES=3, mode 0, pc_in=0,4,8 over 3 cycles after start → stopped=1, count=3, overflow=0; three rd_req → rd_pc 0,4,8, then rd_valid=0 on a 4th rd_req.
- DEPTH=4, MAX_CYCLES=6, mode 0, pc 0..20 step 4 → count=4, overflow=1, readout pc 8,12,16,20.
- mode 1, estado_in 1,1,2,2,2,3 with MAX_CYCLES=6 → count=3, readout estado 1,2,3.
- MAX_CYCLES=0, run 100 cycles, pulse stop → stopped=1 only after stop, count=DEPTH, overflow=1.
- Assert reset during readout with count=2 → next cycle count=0, stopped=0, rd_valid=0; start with rd_req on the same edge → CAPTURE, rd_valid=0.
- Build without TRACE_ULA_EN, ula_in=0xDEAD → rd_ula=0 on every pop.

Source files
------------

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: capture/readout bus of the CPU trace buffer.
//   master modport: drives control (start, stop, mode), CPU sample inputs and rd_req;
//                   observes popped entry, count and status flags.
//   slave modport : the trace buffer itself.
// CNT_W must equal $clog2(DEPTH+1) of the attached buffer.
interface cpu_trace_buffer_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned STATE_W = 5,
  parameter int unsigned CNT_W   = 5
) ();
  logic               start;
  logic               stop;
  logic               mode;
  logic [DATA_W-1:0]  pc_in;
  logic [31:0]        opcode_in;
  logic [STATE_W-1:0] estado_in;
  logic [DATA_W-1:0]  ula_in;
  logic               rd_req;
  logic               rd_valid;
  logic [DATA_W-1:0]  rd_pc;
  logic [31:0]        rd_opcode;
  logic [STATE_W-1:0] rd_estado;
  logic [DATA_W-1:0]  rd_ula;
  logic [CNT_W-1:0]   count;
  logic               capturing;
  logic               stopped;
  logic               overflow;

  modport master (
    output start, stop, mode, pc_in, opcode_in, estado_in, ula_in, rd_req,
    input  rd_valid, rd_pc, rd_opcode, rd_estado, rd_ula, count, capturing, stopped, overflow
  );

  modport slave (
    input  start, stop, mode, pc_in, opcode_in, estado_in, ula_in, rd_req,
    output rd_valid, rd_pc, rd_opcode, rd_estado, rd_ula, count, capturing, stopped, overflow
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular trace capture of PC / opcode / FSM state / ULA result for the
// multicycle CPU, with oldest-first readout once stopped.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : start/stop/mode control, CPU sample inputs, rd_req/rd_valid read port,
//                  popped entry fields, count, capturing, stopped, sticky overflow
// Optional feature: define TRACE_ULA_EN to store the ULA field; otherwise rd_ula is 0.
module cpu_trace_buffer #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STATE_W    = 5,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 30,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input logic                clock,
  input logic                reset,
  cpu_trace_buffer_if.slave  bus
);
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CycW     = (MAX_CYCLES > 0) ? $clog2(MAX_CYCLES + 1) : 1;
  localparam bit          AutoStop = (MAX_CYCLES != 0);
  localparam int unsigned MaxM1    = AutoStop ? MAX_CYCLES - 1 : 0;

  typedef enum logic [1:0] {StIdle, StCapture, StStopped} state_e;

  state_e             state_q;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CycW-1:0]    cyc_q;
  logic               overflow_q;
  logic [STATE_W-1:0] prev_estado_q;
  logic               first_q;  // first CAPTURE cycle of a run, always samples
  logic               rd_valid_q;
  logic [DATA_W-1:0]  rd_pc_q;
  logic [31:0]        rd_opcode_q;
  logic [STATE_W-1:0] rd_estado_q;

  logic [DATA_W-1:0]  mem_pc     [DEPTH];
  logic [31:0]        mem_opcode [DEPTH];
  logic [STATE_W-1:0] mem_estado [DEPTH];

  logic do_wr, full, last_cyc;

  always_comb begin
    do_wr    = (state_q == StCapture) && !bus.start &&
               (!bus.mode || first_q || (bus.estado_in != prev_estado_q));
    full     = (count_q == CNT_W'(DEPTH));
    // This edge brings the cycle counter to MAX_CYCLES.
    last_cyc = AutoStop && (cyc_q == CycW'(MaxM1));
  end

  // Buffer RAM deliberately has no reset.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem_pc[wr_ptr_q]     <= bus.pc_in;
      mem_opcode[wr_ptr_q] <= bus.opcode_in;
      mem_estado[wr_ptr_q] <= bus.estado_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cyc_q         <= '0;
      overflow_q    <= 1'b0;
      prev_estado_q <= '0;
      first_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_pc_q       <= '0;
      rd_opcode_q   <= '0;
      rd_estado_q   <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (bus.start) begin
        state_q    <= StCapture;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        cyc_q      <= '0;
        overflow_q <= 1'b0;
        first_q    <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.stop) state_q <= StStopped;
          end
          StCapture: begin
            first_q       <= 1'b0;
            prev_estado_q <= bus.estado_in;
            if (do_wr) begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              if (full) begin
                // Overwrite oldest: read pointer follows the write pointer.
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                overflow_q <= 1'b1;
              end else begin
                count_q <= count_q + 1'b1;
              end
            end
            if (cyc_q != CycW'(MAX_CYCLES)) cyc_q <= cyc_q + 1'b1;
            if (bus.stop || last_cyc) state_q <= StStopped;
          end
          StStopped: begin
            if (bus.rd_req && (count_q != '0)) begin
              rd_valid_q  <= 1'b1;
              rd_pc_q     <= mem_pc[rd_ptr_q];
              rd_opcode_q <= mem_opcode[rd_ptr_q];
              rd_estado_q <= mem_estado[rd_ptr_q];
              rd_ptr_q    <= rd_ptr_q + 1'b1;
              count_q     <= count_q - 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef TRACE_ULA_EN
  logic [DATA_W-1:0] mem_ula [DEPTH];
  logic [DATA_W-1:0] rd_ula_q;

  always_ff @(posedge clock) begin
    if (do_wr) mem_ula[wr_ptr_q] <= bus.ula_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ula_q <= '0;
    end else if (!bus.start && (state_q == StStopped) && bus.rd_req && (count_q != '0)) begin
      rd_ula_q <= mem_ula[rd_ptr_q];
    end
  end

  assign bus.rd_ula = rd_ula_q;
`else
  logic unused_ula;
  assign unused_ula = ^bus.ula_in;
  assign bus.rd_ula = '0;
`endif

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_pc     = rd_pc_q;
  assign bus.rd_opcode = rd_opcode_q;
  assign bus.rd_estado = rd_estado_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.capturing = (state_q == StCapture);
  assign bus.stopped   = (state_q == StStopped);
endmodule
